// File: rtl/dff_shift_reg_universal.sv
// -----------------------------------------------------------------------------
// dff_shift_reg_universal
//
// Parametrised universal register. It holds a WIDTH-bit word and changes it
// only on the rising edge of clk. A clock enable gates every operation, and a
// 3-bit mode selects one of eight operations: hold, parallel load,
// logical shift left/right, rotate left/right, clear, and arithmetic shift
// right.
//
// Per-edge priority: reset > (en == 0 -> hold) > mode.
//
// Parameters
//   WIDTH        register width in bits (>= 2)
//   RESET_VALUE  value loaded into q by reset
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; q <= RESET_VALUE
//   en         clock enable; 0 holds q whatever the mode
//   mode       operation select (see mode_e)
//   d          parallel load data (LOAD only)
//   ser_in     serial input bit (SHL / SHR only)
//   q          registered contents
//   ser_out_l  q[WIDTH-1], the bit that leaves on a left shift
//   ser_out_r  q[0], the bit that leaves on a right shift
//   zero       1 when q == 0
// -----------------------------------------------------------------------------
module dff_shift_reg_universal #(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic             zero
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_CLR  = 3'b110,
        MODE_ASR  = 3'b111
    } mode_e;

    logic [WIDTH-1:0] q_next;

    // Each arm reads only the inputs its operation needs. An unknown d or
    // ser_in therefore cannot reach q in the modes that do not use it.
    always_comb begin
        // NOTE: q_next gets a default before the case so that no path leaves
        // it unassigned; otherwise a latch would be inferred.
        q_next = q;
        case (mode_e'(mode))
            MODE_HOLD: q_next = q;
            MODE_LOAD: q_next = d;
            MODE_SHL:  q_next = {q[WIDTH-2:0], ser_in};
            MODE_SHR:  q_next = {ser_in, q[WIDTH-1:1]};
            MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            MODE_CLR:  q_next = '0;                       // independent of RESET_VALUE
            MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]}; // sign bit replicated
            default:   q_next = q;
        endcase
    end

    // Reset is sampled only at the edge. A pulse that rises and falls between
    // two edges is never seen.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment here, so every register samples its
        // inputs from before the edge. This prevents ordering races between
        // always_ff blocks.
        if (reset)
            q <= RESET_VALUE;
        else if (en)
            q <= q_next;
    end

    assign ser_out_l = q[WIDTH-1];
    assign ser_out_r = q[0];
    assign zero      = (q == '0);

endmodule

// File: tb/tb_dff_shift_reg_universal.sv
// -----------------------------------------------------------------------------
// tb_dff_shift_reg_universal
//
// Two instances share every input: one has RESET_VALUE = 8'h00 and the other
// has RESET_VALUE = 8'h3C. After each edge, the driver advances an arithmetic
// reference model and pushes the expected q of both instances into a
// scoreboard queue. On the following falling edge, a monitor pops that entry
// and compares q, ser_out_l, ser_out_r and zero on both instances.
// -----------------------------------------------------------------------------
module tb_dff_shift_reg_universal;

    localparam int W = 8;
    localparam logic [W-1:0] RV1 = 8'h3C;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic [2:0]   mode = 3'd0;
    logic [W-1:0] d = '0;
    logic         ser_in = 1'b0;

    logic [W-1:0] q0, q1;
    logic         sol0, sor0, zero0, sol1, sor1, zero1;

    dff_shift_reg_universal #(.WIDTH(W), .RESET_VALUE(8'h00)) dut0 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d), .ser_in(ser_in),
        .q(q0), .ser_out_l(sol0), .ser_out_r(sor0), .zero(zero0)
    );

    dff_shift_reg_universal #(.WIDTH(W), .RESET_VALUE(RV1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d), .ser_in(ser_in),
        .q(q1), .ser_out_l(sol1), .ser_out_r(sor1), .zero(zero1)
    );

    always #10 clk = ~clk;

    typedef struct {
        string name;
        int    exp0;
        int    exp1;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    // Reference model: register contents held as plain integers 0..255.
    int mdl0, mdl1;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int apply_op(input int v, input int m, input int dv, input int s);
        case (m)
            0: return v;
            1: return dv;
            2: return (v * 2 + s) % 256;
            3: return v / 2 + s * 128;
            4: return (v * 2) % 256 + v / 128;
            5: return v / 2 + (v % 2) * 128;
            6: return 0;
            default: return v / 2 + ((v >= 128) ? 128 : 0);
        endcase
    endfunction

    task automatic model_edge(input bit r, input bit e, input int m, input int dv, input int s,
                              input string name);
        exp_t x;
        if (r) begin
            mdl0 = 0;
            mdl1 = int'(RV1);
        end else if (e) begin
            mdl0 = apply_op(mdl0, m, dv, s);
            mdl1 = apply_op(mdl1, m, dv, s);
        end
        x.name = name;
        x.exp0 = mdl0;
        x.exp1 = mdl1;
        sb.push_back(x);
    endtask

    // One clock: drive the inputs on the falling edge, wait for the active edge,
    // then record what the model expects.
    task automatic step(input bit r, input bit e, input int m, input int dv, input int s,
                        input string name);
        @(negedge clk);
        reset  = r;
        en     = e;
        mode   = 3'(m);
        d      = 8'(dv);
        ser_in = s[0];
        @(posedge clk);
        #1;
        model_edge(r, e, m, dv, s, name);
    endtask

    // Monitor: checks every scoreboard entry one falling edge after its edge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t x;
            x = sb.pop_front();
            check({x.name, " q0"},    int'(q0),    x.exp0);
            check({x.name, " sol0"},  int'(sol0),  int'(x.exp0 >= 128));
            check({x.name, " sor0"},  int'(sor0),  x.exp0 % 2);
            check({x.name, " zero0"}, int'(zero0), int'(x.exp0 == 0));
            check({x.name, " q1"},    int'(q1),    x.exp1);
            check({x.name, " sol1"},  int'(sol1),  int'(x.exp1 >= 128));
            check({x.name, " sor1"},  int'(sor1),  x.exp1 % 2);
            check({x.name, " zero1"}, int'(zero1), int'(x.exp1 == 0));
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        mdl0 = 0;
        mdl1 = 0;

        // Reset held for two edges, then a parallel load.
        step(1, 0, 0, 8'h00, 0, "reset_a");
        step(1, 1, 1, 8'hFF, 0, "reset_b");
        step(0, 1, 1, 8'hA5, 0, "load_a5");
        check("load_a5 const", int'(q0), 8'hA5);

        // Eight logical left shifts with ser_in = 0 empty the register.
        for (int i = 0; i < 8; i++) step(0, 1, 2, $urandom_range(255), 0, "shl0");
        check("shl x8 empty", int'(zero0), 1);

        // Rotates.
        step(0, 1, 1, 8'h81, 1, "load_81");
        step(0, 1, 4, 8'h00, 1, "rol");
        step(0, 1, 5, 8'h00, 0, "ror1");
        step(0, 1, 5, 8'h00, 1, "ror2");
        check("ror2 const", int'(q0), 8'hC0);
        step(0, 1, 1, 8'h5A, 0, "load_5a");
        for (int i = 0; i < 8; i++) step(0, 1, 4, $urandom_range(255), $urandom_range(1), "rol8");
        check("rol x8 identity", int'(q0), 8'h5A);

        // Arithmetic shift right from 0x80 and from all-ones.
        step(0, 1, 1, 8'h80, 0, "load_80");
        for (int i = 0; i < 3; i++) step(0, 1, 7, 8'h00, 0, "asr");
        check("asr x3 const", int'(q0), 8'hF0);
        step(0, 1, 1, 8'hFF, 0, "load_ff");
        step(0, 1, 7, 8'h00, 0, "asr_ones");

        // Right shifts with ser_in = 1, starting from a cleared register.
        step(0, 1, 6, 8'hFF, 1, "clr");
        step(0, 1, 3, 8'h00, 1, "shr1_a");
        step(0, 1, 3, 8'h00, 1, "shr1_b");
        check("shr1 x2 const", int'(q0), 8'hC0);

        // en = 0 holds q in every mode. Then CLR, then reset (0x00 vs 0x3C).
        step(0, 0, 6, 8'h00, 0, "en0_clr");
        step(0, 0, 1, 8'h11, 0, "en0_load");
        step(0, 0, 6, 8'h00, 1, "en0_clr2");
        step(0, 1, 6, 8'h00, 0, "en1_clr");
        step(1, 1, 2, 8'h00, 1, "reset_rv");
        check("reset rv1 const", int'(q1), int'(RV1));

        // A reset on the edge wins over a pending LOAD 0xFF.
        step(0, 1, 1, 8'h96, 0, "load_96");
        step(0, 1, 2, 8'h00, 1, "shl_mid");
        step(1, 1, 1, 8'hFF, 0, "reset_over_load");

        // A reset pulse between edges is ignored; the SHL on this edge still
        // happens.
        step(0, 1, 1, 8'h6B, 0, "load_6b");
        @(negedge clk);
        en = 1'b1; mode = 3'd2; d = 8'h00; ser_in = 1'b1;
        #2 reset = 1'b1;
        #5 reset = 1'b0;
        @(posedge clk);
        #1;
        model_edge(0, 1, 2, 0, 1, "reset_glitch");

        // Randomised operation mix, with an occasional reset.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(31) == 0), ($urandom_range(7) != 0), $urandom_range(7),
                 $urandom_range(255), $urandom_range(1), "random");
        end

        // Drain the scoreboard, with a bound.
        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        check("scoreboard drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
